// File: rtl/alu_pkg.sv
// alu_pkg: function codes, FSM encoding and flag bit indices shared by alu_seq.
package alu_pkg;
   localparam logic [2:0] F_ADD = 3'b000, F_SUB = 3'b001, F_AND = 3'b010, F_OR = 3'b011;
   localparam logic [2:0] F_XOR = 3'b100, F_SHL = 3'b101, F_SHR = 3'b110, F_NOT = 3'b111;
   localparam logic [1:0] S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2, S_RESP = 2'd3;
   localparam int FL_C = 3, FL_Z = 2, FL_V = 1, FL_S = 0;
   // these functions cannot be chained across two 16-bit halves
   function automatic logic wide_illegal(input logic [2:0] f);
      return f == F_SUB || f == F_SHL || f == F_SHR;
   endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between a requester and alu_seq.
interface alu_seq_if;
   logic        req_valid, req_ready, req_wide, req_use_c, req_set_flags;
   logic [2:0]  req_func;
   logic [31:0] req_a, req_b;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_data;
   logic [3:0]  resp_flags;
   modport master (output req_valid, req_func, req_wide, req_use_c, req_set_flags, req_a, req_b, resp_ready,
                   input req_ready, resp_valid, resp_data, resp_flags, resp_err);
   modport slave  (input req_valid, req_func, req_wide, req_use_c, req_set_flags, req_a, req_b, resp_ready,
                   output req_ready, resp_valid, resp_data, resp_flags, resp_err);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequences 16/32-bit operations over an external 16-bit ALU, one op in flight.
module alu_seq
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   alu_seq_if.slave    bus,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_func,
   output logic        cin,
   input  logic [15:0] alu_out,
   input  logic        alu_c,
   input  logic        alu_z,
   input  logic        alu_v,
   input  logic        alu_s,
   output logic        flag_c,
   output logic        flag_z,
   output logic        flag_v,
   output logic        flag_s
);
   logic [1:0]  r_state;
   logic [2:0]  r_func;
   logic        r_wide, r_use_c, r_set_flags, r_err;
   logic [31:0] r_a, r_b, r_data;
   logic [15:0] r_lo;
   logic [3:0]  r_lo_f, r_flags, r_fr;
   logic        w_lo, w_hi, w_acc, w_done;
   logic [3:0]  w_alu_f;

   assign w_lo    = r_state == S_LO;
   assign w_hi    = r_state == S_HI;
   assign w_acc   = bus.req_valid && bus.req_ready;
   assign w_done  = bus.resp_valid && bus.resp_ready;
   assign w_alu_f = {alu_c, alu_z, alu_v, alu_s};

   assign bus.req_ready  = r_state == S_IDLE;
   assign bus.resp_valid = r_state == S_RESP;
   assign bus.resp_data  = r_data;
   assign bus.resp_flags = r_flags;
   assign bus.resp_err   = r_err;

   assign alu_a    = w_lo ? r_a[15:0] : w_hi ? r_a[31:16] : 16'h0;
   assign alu_b    = w_lo ? r_b[15:0] : w_hi ? r_b[31:16] : 16'h0;
   assign alu_func = (w_lo || w_hi) ? r_func : F_ADD;
   // upper half of a wide add continues the carry chain from the lower half
   assign cin      = w_lo ? r_use_c & r_fr[FL_C] : w_hi ? (r_func == F_ADD) & r_lo_f[FL_C] : 1'b0;
   assign {flag_c, flag_z, flag_v, flag_s} = r_fr;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state     <= S_IDLE;
         r_func      <= '0;
         r_wide      <= 1'b0;
         r_use_c     <= 1'b0;
         r_set_flags <= 1'b0;
         r_err       <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_data      <= '0;
         r_lo        <= '0;
         r_lo_f      <= '0;
         r_flags     <= '0;
         r_fr        <= '0;
      end else
         case (r_state)
            S_IDLE: if (w_acc) begin
               r_func      <= bus.req_func;
               r_wide      <= bus.req_wide;
               r_use_c     <= bus.req_use_c;
               r_set_flags <= bus.req_set_flags;
               r_a         <= bus.req_a;
               r_b         <= bus.req_b;
               r_err       <= bus.req_wide && wide_illegal(bus.req_func);
               r_data      <= '0;
               r_flags     <= r_fr;
               r_state     <= (bus.req_wide && wide_illegal(bus.req_func)) ? S_RESP : S_LO;
            end
            S_LO: begin
               r_lo    <= alu_out;
               r_lo_f  <= w_alu_f;
               r_data  <= {16'h0, alu_out};
               r_flags <= w_alu_f;
               r_state <= r_wide ? S_HI : S_RESP;
            end
            S_HI: begin
               r_data  <= {alu_out, r_lo};
               r_flags <= {alu_c, alu_z & r_lo_f[FL_Z], alu_v, alu_s};
               r_state <= S_RESP;
            end
            default: if (w_done) begin
               if (r_set_flags && !r_err) r_fr <= r_flags;
               r_state <= S_IDLE;
            end
         endcase
endmodule
